bmp_stream_parser: RTL and testbench
====================================

# bmp_stream_parser

Upstream feeder for `image_processing_acclerator`: accepts a raw BMP file as byte-packed 32-bit words, parses and validates the BITMAPFILEHEADER/INFOHEADER fields, and strips the header. It re-aligns the pixel payload, which starts at a non-word-aligned `data_offset`, into packed 32-bit words on a valid/ready stream for the accelerator's `slv0` port. It ends each frame with a `last`-tagged, byte-qualified final word.

## Interface
- `DATA_WIDTH`, 32, stream width; only 32 is legal (4 byte lanes).
- `MIN_OFFSET`, 30, smallest legal `data_offset` (end of parsed header fields).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; arms parsing of a new file (ignored in PARSE/FLUSH).
- `in_data`  in  32  file bytes; byte n at [31:24], n+1 at [23:16], n+2 at [15:8], n+3 at [7:0].
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  parser accepts word; transfer on `in_valid && in_ready`.
- `out_data`  out  32  payload bytes, same lane order as input.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts; transfer on `out_valid && out_ready`.
- `out_last`  out  1  final payload word of file.
- `out_bytes`  out  3  valid bytes in `out_data` (1..4, MSB lanes first); 4 except possibly on `out_last`.
- `file_size`, `data_offset`, `img_width`, `img_height`  out  32 each  little-endian header fields (bytes 2-5, 10-13, 18-21, 22-25).
- `bit_count`  out  16  bytes 28-29.
- `hdr_valid`  out  1  all header fields captured and checked.
- `done`  out  1  file fully emitted.
- `err`  out  1  header invalid; sticky until `start` or `rst`.

## Operation
- States: IDLE, PARSE, FLUSH, DONE, ERR. Reset → IDLE with all outputs 0, `byte_cnt` = 0, `fill` = 0.
- IDLE: `in_ready` = 0. `start` → PARSE, clears header registers, `hdr_valid`, `done`, `err`, `byte_cnt`, `fill`.
- PARSE: `in_ready` = (`fill` ≤ 4). Each accepted word classifies lanes by index `byte_cnt + lane`:
  - Indices 0-29: header capture.
  - Indices ≥ `data_offset` and < `file_size`: payload, appended to an 8-byte realignment buffer in order.
  - All others are discarded.
  - `byte_cnt` += 4 per accepted word.
- Checks:
  - After word 0: bytes 0,1 ≠ 0x42,0x4D → ERR.
  - After word 3 (byte 13 consumed): `data_offset` < `MIN_OFFSET` or `data_offset` > `file_size` → ERR.
  - `hdr_valid` is set after word 7 is accepted.
- Accepting a word with `byte_cnt + 4` ≥ `file_size` → FLUSH. Lanes past `file_size` in that word are ignored.
- Output:
  - `out_data` = top 4 buffer bytes.
  - `out_valid` = (`fill` ≥ 4) || (FLUSH && `fill` > 0).
  - `out_last` = FLUSH && `fill` ≤ 4.
  - `out_bytes` = min(`fill`, 4).
  - Output fire: buffer shifts up 4 bytes, `fill` -= `out_bytes`.
- Simultaneous in/out fire: `fill'` = `fill` − `out_bytes` + payload lanes; new bytes pack directly behind survivors.
- FLUSH: `in_ready` = 0. Fire with `out_last` → DONE.
- DONE: `done` = 1, `in_ready` = 0, `out_valid` = 0; `start` → PARSE.
- ERR: `err` = 1, `in_ready` = 0, `out_valid` = 0, `hdr_valid` = 0; buffer discarded; `start` → PARSE.
- A payload of 0 bytes (`data_offset` == `file_size`) goes straight from FLUSH to DONE without `out_valid`.
- `rst` in any state returns to IDLE next cycle; partial frame discarded.

## Timing
- `in_ready` and `out_*` are functions of registered state only; no `out_ready`→`in_ready` combinational path.
- `out_valid` rises the cycle after the accepting edge that brings `fill` ≥ 4 (1-cycle latency).
- Sustained throughput is 1 word/cycle in and out when `out_ready` = 1.
- `err` asserts the cycle after the offending word is accepted.
- `done` asserts the cycle after the `out_last` transfer.
- Held `out_*` are stable while `out_valid && !out_ready`.

## Configuration
- `BMP_BITCOUNT_CHECK_EN` defined: after word 7, `bit_count` ∉ {24, 32} → ERR.
- Undefined: `bit_count` is captured and reported only, never checked.

## Test plan
- 2×2 24bpp file, `file_size` 70, `data_offset` 54, 18 words in, `out_ready` = 1:
  - 4 output words carrying bytes 54..69 in order.
  - `out_bytes` = 4 on all words; `out_last` on the 4th.
  - `img_width` = 2, `img_height` = 2, `bit_count` = 24, `hdr_valid` set; `done` next cycle.
- Same file with `file_size` 71:
  - 5 output words; last has `out_bytes` = 1 and `out_last`, holding byte 70 at [31:24].
- Signature 0x42,0x4E:
  - `err` = 1 the cycle after word 0; no `out_valid`; `start` restarts cleanly on a good file.
- `data_offset` = 20:
  - ERR after word 3.
  - Macro defined with `bit_count` = 16: ERR after word 7. Macro undefined: normal output.
- Random `out_ready` stall pattern and `rst` asserted mid-payload:
  - No byte lost or duplicated, `out_*` stable while stalled.
  - After reset: IDLE, all outputs 0, next file parses correctly.

Source files
------------

// File: rtl/bmp_stream_parser.sv
// bmp_stream_parser: parses BMP file/info headers and realigns the pixel payload into packed 32-bit words (BMP_BITCOUNT_CHECK_EN enables the bit_count check)
module bmp_stream_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int MIN_OFFSET = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [2:0]            out_bytes,
    output logic [31:0]           file_size,
    output logic [31:0]           data_offset,
    output logic [31:0]           img_width,
    output logic [31:0]           img_height,
    output logic [15:0]           bit_count,
    output logic                  hdr_valid,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, PARSE, FLUSH, DONE, ERR} state_t;
`ifdef BMP_BITCOUNT_CHECK_EN
    localparam bit BC_CHK = 1'b1;
`else
    localparam bit BC_CHK = 1'b0;
`endif
    state_t      state_q, state_d;
    logic [31:0] byte_cnt_q, byte_cnt_d, fs_q, fs_d, off_q, off_d, wid_q, wid_d, hgt_q, hgt_d;
    logic [15:0] bc_q, bc_d;
    logic        hv_q, hv_d;
    logic [3:0]  fill_q, fill_d, fill_s;
    logic [63:0] buf_q, buf_d, buf_s;
    logic [3:0]  pay;
    logic [2:0]  n;
    logic [1:0]  lo;
    logic [31:0] lo_b, w;
    logic        in_fire, out_fire, bad, flush;
    logic [7:0]  b0, b1, b2, b3;

    assign {b0, b1, b2, b3} = in_data;
    assign in_ready  = state_q == PARSE && fill_q <= 4'd4;
    assign out_valid = (state_q == PARSE && fill_q >= 4'd4) || (state_q == FLUSH && fill_q != 4'd0);
    assign out_last  = state_q == FLUSH && fill_q <= 4'd4;
    assign out_bytes = fill_q >= 4'd4 ? 3'd4 : fill_q[2:0];
    assign out_data  = buf_q[63:32];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign lo_b      = off_q > 32'(MIN_OFFSET) ? off_q : 32'(MIN_OFFSET);
    for (genvar l = 0; l < 4; l++) begin : g_lane
        assign pay[l] = byte_cnt_q + 32'(l) >= lo_b && byte_cnt_q + 32'(l) < fs_q;
    end
    // payload lanes of one word are contiguous, so left-justify them and mask off the tail
    assign n      = 3'(pay[0]) + 3'(pay[1]) + 3'(pay[2]) + 3'(pay[3]);
    assign lo     = pay[0] ? 2'd0 : pay[1] ? 2'd1 : pay[2] ? 2'd2 : 2'd3;
    assign w      = (in_data << {lo, 3'b000}) & ~(32'hFFFF_FFFF >> {n, 3'b000});
    assign fill_s = fill_q - (out_fire ? {1'b0, out_bytes} : 4'd0);
    assign buf_s  = out_fire ? {buf_q[31:0], 32'd0} : buf_q;
    assign flush  = byte_cnt_q >= 32'd28 && {1'b0, byte_cnt_q} + 33'd4 >= {1'b0, fs_q};
    assign file_size   = fs_q;
    assign data_offset = off_q;
    assign img_width   = wid_q;
    assign img_height  = hgt_q;
    assign bit_count   = bc_q;
    assign hdr_valid   = hv_q;
    assign done        = state_q == DONE;
    assign err         = state_q == ERR;

    // header capture, buffer shift/append and state sequencing
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        fs_d       = fs_q;
        off_d      = off_q;
        wid_d      = wid_q;
        hgt_d      = hgt_q;
        bc_d       = bc_q;
        hv_d       = hv_q;
        fill_d     = fill_s;
        buf_d      = buf_s;
        bad        = 1'b0;
        if (in_fire) begin
            byte_cnt_d = byte_cnt_q + 32'd4;
            fill_d     = fill_s + {1'b0, n};
            buf_d      = buf_s | ({w, 32'd0} >> {fill_s, 3'b000});
            if (byte_cnt_q < 32'd32) begin
                case (byte_cnt_q[4:2])
                    3'd0: begin fs_d[15:0] = {b3, b2}; bad = b0 != 8'h42 || b1 != 8'h4D; end
                    3'd1: fs_d[31:16] = {b1, b0};
                    3'd2: off_d[15:0] = {b3, b2};
                    3'd3: begin off_d[31:16] = {b1, b0}; bad = off_d < 32'(MIN_OFFSET) || off_d > fs_q; end
                    3'd4: wid_d[15:0] = {b3, b2};
                    3'd5: begin wid_d[31:16] = {b1, b0}; hgt_d[15:0] = {b3, b2}; end
                    3'd6: hgt_d[31:16] = {b1, b0};
                    default: begin bc_d = {b1, b0}; hv_d = 1'b1; bad = BC_CHK && bc_d != 16'd24 && bc_d != 16'd32; end
                endcase
            end
        end
        case (state_q)
            PARSE: begin
                if (bad) begin
                    state_d = ERR;
                    fill_d  = 4'd0;
                    buf_d   = '0;
                    hv_d    = 1'b0;
                end else if (in_fire && flush) state_d = FLUSH;
            end
            FLUSH: if (fill_q == 4'd0 || (out_fire && out_last)) state_d = DONE;
            default: begin
                if (start) begin
                    state_d    = PARSE;
                    byte_cnt_d = '0;
                    fs_d       = '0;
                    off_d      = '0;
                    wid_d      = '0;
                    hgt_d      = '0;
                    bc_d       = '0;
                    hv_d       = 1'b0;
                    fill_d     = 4'd0;
                    buf_d      = '0;
                end
            end
        endcase
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            fs_q       <= '0;
            off_q      <= '0;
            wid_q      <= '0;
            hgt_q      <= '0;
            bc_q       <= '0;
            hv_q       <= 1'b0;
            fill_q     <= 4'd0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            fs_q       <= fs_d;
            off_q      <= off_d;
            wid_q      <= wid_d;
            hgt_q      <= hgt_d;
            bc_q       <= bc_d;
            hv_q       <= hv_d;
            fill_q     <= fill_d;
            buf_q      <= buf_d;
        end
    end
endmodule

// File: tb/tb_bmp_stream_parser.sv
// tb_bmp_stream_parser: directed checks of header parsing, payload realignment, errors, stalls and reset
module tb_bmp_stream_parser;
`ifdef BMP_BITCOUNT_CHECK_EN
    localparam logic BC_ERR = 1'b1;
`else
    localparam logic BC_ERR = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_last, hdr_valid, done, err;
    logic [31:0] out_data, file_size, data_offset, img_width, img_height;
    logic [2:0]  out_bytes;
    logic [15:0] bit_count;
    int          n_chk = 0, n_fail = 0, wc = 0, cur_fs = 0, base = 0, nb;
    logic [7:0]  fbuf [0:127];
    logic [7:0]  exp_q [$];
    logic [7:0]  eb;
    bit          stall_mode = 1'b0, hv_o = 1'b0, pend = 1'b0;
    logic [35:0] hold = '0;
    logic [2:0]  last_b = '0;

    bmp_stream_parser dut (
        .clk(clk), .rst(rst), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_bytes(out_bytes),
        .file_size(file_size), .data_offset(data_offset),
        .img_width(img_width), .img_height(img_height), .bit_count(bit_count),
        .hdr_valid(hdr_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build(input int fs, input int off, input logic [15:0] bc, input logic [7:0] s1);
        for (int i = 0; i < 128; i++) fbuf[i] = 8'(i * 7 + 3);
        fbuf[0] = 8'h42;
        fbuf[1] = s1;
        {fbuf[5], fbuf[4], fbuf[3], fbuf[2]} = 32'(fs);
        {fbuf[13], fbuf[12], fbuf[11], fbuf[10]} = 32'(off);
        {fbuf[21], fbuf[20], fbuf[19], fbuf[18]} = 32'd2;
        {fbuf[25], fbuf[24], fbuf[23], fbuf[22]} = 32'd2;
        {fbuf[29], fbuf[28]} = bc;
        cur_fs = fs;
        exp_q.delete();
        for (int i = off; i < fs; i++) exp_q.push_back(fbuf[i]);
    endtask

    task automatic pulse_start();
        base = wc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            int t = 0;
            in_data = {fbuf[4*i], fbuf[4*i+1], fbuf[4*i+2], fbuf[4*i+3]};
            in_valid = 1'b1;
            while (!in_ready && !err && !done && t < 200) begin @(posedge clk); #1; t++; end
            if (!in_ready) begin
                if (!err && !done) check("in_timeout", in_ready, 1'b1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 1000) begin @(posedge clk); #1; t++; end
        check("done", done, 1'b1);
    endtask

    task automatic run_file(input int nw);
        pulse_start();
        send(0, (cur_fs + 3) / 4);
        wait_done();
        check("words", wc - base, nw);
        check("left", exp_q.size(), 0);
    endtask

    task automatic idle_checks();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", {out_data, out_bytes}, 0);
        check("rst_hdr", {file_size, data_offset, img_width, img_height, bit_count, hdr_valid}, 0);
        check("rst_done_err", {done, err}, 2'b00);
    endtask

    // output scoreboard: byte order, byte counts, last tag, hold stability, done latency
    always @(negedge clk) begin
        if (rst) begin
            hv_o = 1'b0;
            pend = 1'b0;
        end else begin
            if (hv_o) check("hold", {out_data, out_bytes, out_last}, hold);
            if (err || done) check("ov_idle", out_valid, 1'b0);
            if (pend) check("done_lat", done, 1'b1);
            pend = 1'b0;
            if (out_valid && out_ready) begin
                wc++;
                nb = exp_q.size();
                check("bytes", out_bytes, nb > 4 ? 4 : nb);
                for (int k = 0; k < int'(out_bytes); k++) begin
                    if (exp_q.size() != 0) eb = exp_q.pop_front();
                    else eb = 8'hxx;
                    check("byte", out_data[31-8*k -: 8], eb);
                end
                check("last", out_last, exp_q.size() == 0);
                last_b = out_bytes;
                if (out_last) pend = 1'b1;
            end
            hv_o = out_valid && !out_ready;
            hold = {out_data, out_bytes, out_last};
        end
    end

    initial begin
        fork
            forever begin
                @(posedge clk); #1;
                if (stall_mode) out_ready = $urandom_range(0, 1) != 0;
            end
        join_none
        repeat (2) @(posedge clk);
        #1;
        idle_checks();
        rst = 1'b0;
        build(70, 54, 16'd24, 8'h4D);
        run_file(4);
        check("f70_hdr", {file_size, data_offset}, {32'd70, 32'd54});
        check("f70_dims", {img_width, img_height, bit_count}, {32'd2, 32'd2, 16'd24});
        check("f70_hv", hdr_valid, 1'b1);
        build(71, 54, 16'd24, 8'h4D);
        run_file(5);
        check("f71_last_bytes", last_b, 3'd1);
        build(70, 54, 16'd24, 8'h4E);
        pulse_start();
        send(0, 1);
        check("sig_err", err, 1'b1);
        check("sig_in_ready", in_ready, 1'b0);
        check("sig_hv", hdr_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("sig_sticky", err, 1'b1);
        check("sig_words", wc - base, 0);
        build(70, 54, 16'd24, 8'h4D);
        run_file(4);
        check("restart_err", err, 1'b0);
        check("restart_hv", hdr_valid, 1'b1);
        build(70, 20, 16'd24, 8'h4D);
        pulse_start();
        send(0, 3);
        check("off_pre", err, 1'b0);
        send(3, 1);
        check("off_err", err, 1'b1);
        build(70, 54, 16'd16, 8'h4D);
        pulse_start();
        send(0, 8);
        check("bc_err", err, BC_ERR);
        if (!err) begin
            send(8, 10);
            wait_done();
            check("bc_words", wc - base, 4);
            check("bc_val", bit_count, 16'd16);
        end
        stall_mode = 1'b1;
        build(71, 54, 16'd24, 8'h4D);
        run_file(5);
        build(70, 54, 16'd24, 8'h4D);
        pulse_start();
        send(0, 16);
        rst = 1'b1;
        @(posedge clk); #1;
        idle_checks();
        rst = 1'b0;
        stall_mode = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        build(70, 54, 16'd24, 8'h4D);
        run_file(4);
        check("post_rst_dims", {img_width, img_height, hdr_valid}, {32'd2, 32'd2, 1'b1});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
